// File: rtl/trace_port_receiver.sv
// Capture side of the 4-bit parallel trace port.
// Hunts for the FF FF FF 7F sync frame to find byte alignment. Once aligned,
// it packs nibble pairs (low nibble first) into bytes and pushes them into a
// first-word-fall-through FIFO that is drained with a valid/ready handshake.
module trace_port_receiver #(
    parameter int pFIFO_AW = 4
) (
    input  logic       trace_clk,
    input  logic       reset,
    input  logic [3:0] TRACEDATA,
    input  logic       enable,
    input  logic       clear,
    output logic [7:0] trace_data,
    output logic       trace_valid,
    input  logic       trace_ready,
    output logic       synced,
    output logic       realign,
    output logic       overflow,
    output logic [7:0] drop_count
);

    localparam int DEPTH = 2 ** pFIFO_AW;
    // Window holds the newest nibble in the top bits. The oldest-to-newest
    // sequence F,F,F,F,F,F,F,7 therefore reads 7FFFFFFF.
    localparam logic [31:0]       SYNC_PAT = 32'h7FFF_FFFF;
    localparam logic [pFIFO_AW:0] PTR_ONE  = {{pFIFO_AW{1'b0}}, 1'b1};

    typedef enum logic {HUNT, SYNCED} state_t;

    state_t      state_q, state_d;
    logic [3:0]  td_q;
    logic [31:0] sr_q, sr_d;
    logic [31:0] window;
    logic        phase_q, phase_d;
    logic [3:0]  lo_q, lo_d;
    logic        realign_q, realign_d;
    logic        match;
    logic        wr_req;
    logic [7:0]  wr_byte;

    logic [pFIFO_AW:0] wptr_q, rptr_q;
    logic [7:0]        mem_q [DEPTH];
    logic              full, empty, rd_en, wr_en, drop;
    logic              overflow_q;
    logic [7:0]        drop_q;

    // The match window includes the freshly registered nibble.
    // This lets the state change on the edge right after the 7 lands in td_q.
    assign window = {td_q, sr_q[31:4]};
    assign match  = (window == SYNC_PAT);

    // Input register for the pin nibble.
    always_ff @(posedge trace_clk or negedge reset) begin
        if (!reset) td_q <= 4'h0;
        else        td_q <= TRACEDATA;
    end

    // Alignment state, nibble history, pending low nibble and realign pulse.
    always_ff @(posedge trace_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= HUNT;
            sr_q      <= '0;
            phase_q   <= 1'b0;
            lo_q      <= 4'h0;
            realign_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            phase_q   <= phase_d;
            lo_q      <= lo_d;
            realign_q <= realign_d;
        end
    end

    // Next state: hunt for sync, then alternate low/high nibbles.
    // A sync seen on a low-nibble slot means alignment slipped. That 7 is
    // dropped so the following nibble becomes a low nibble again.
    always_comb begin
        state_d   = state_q;
        sr_d      = window;
        phase_d   = phase_q;
        lo_d      = lo_q;
        realign_d = 1'b0;
        wr_req    = 1'b0;
        wr_byte   = {td_q, lo_q};
        if (!enable) begin
            state_d = HUNT;
            sr_d    = '0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (match) begin
                        state_d = SYNCED;
                        phase_d = 1'b0;
                    end
                end
                SYNCED: begin
                    if (!phase_q) begin
                        if (match) begin
                            realign_d = 1'b1;
                        end else begin
                            lo_d    = td_q;
                            phase_d = 1'b1;
                        end
                    end else begin
                        wr_req  = 1'b1;
                        phase_d = 1'b0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign full  = (wptr_q[pFIFO_AW] != rptr_q[pFIFO_AW]) &&
                   (wptr_q[pFIFO_AW-1:0] == rptr_q[pFIFO_AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign rd_en = !empty && trace_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot for this write.
    assign wr_en = wr_req && (!full || rd_en);
    assign drop  = wr_req && full && !rd_en;

    // FIFO storage. It is not reset, because the head output is gated by empty.
    always_ff @(posedge trace_clk) begin
        if (wr_en && !clear) mem_q[wptr_q[pFIFO_AW-1:0]] <= wr_byte;
    end

    // FIFO pointers. Clear takes priority over any simultaneous push or pop.
    always_ff @(posedge trace_clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clear) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + PTR_ONE;
            if (rd_en) rptr_q <= rptr_q + PTR_ONE;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge trace_clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else if (clear) begin
            overflow_q <= 1'b0;
            drop_q     <= 8'h00;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign trace_valid = !empty;
    assign trace_data  = empty ? 8'h00 : mem_q[rptr_q[pFIFO_AW-1:0]];
    assign synced      = (state_q == SYNCED);
    assign realign     = realign_q;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_trace_port_receiver.sv
// Directed bench for trace_port_receiver. Covers sync acquisition,
// realignment, FIFO overflow and clear, a simultaneous push and pop at full,
// and enable/reset taking effect mid-stream.
module tb_trace_port_receiver;

    logic       trace_clk = 1'b0;
    logic       reset, enable, clear, trace_ready;
    logic [3:0] TRACEDATA;
    logic [7:0] trace_data, drop_count;
    logic       trace_valid, synced, realign, overflow;

    int n_cmp = 0;
    int n_err = 0;

    trace_port_receiver #(.pFIFO_AW(4)) dut (
        .trace_clk  (trace_clk),
        .reset      (reset),
        .TRACEDATA  (TRACEDATA),
        .enable     (enable),
        .clear      (clear),
        .trace_data (trace_data),
        .trace_valid(trace_valid),
        .trace_ready(trace_ready),
        .synced     (synced),
        .realign    (realign),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 trace_clk = ~trace_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present one nibble for one edge, then sample just after that edge.
    task automatic nib(input logic [3:0] n);
        TRACEDATA = n;
        @(posedge trace_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        nib(b[3:0]);
        nib(b[7:4]);
    endtask

    task automatic sync_seq();
        repeat (7) nib(4'hF);
        nib(4'h7);
    endtask

    // Check the head byte, then pop it with a one-cycle ready pulse.
    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, ".valid"}, trace_valid, 1);
        chk(tag, trace_data, exp);
        trace_ready = 1'b1;
        @(posedge trace_clk);
        #1;
        trace_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; clear = 1'b0; trace_ready = 1'b0; TRACEDATA = 4'h0;

        // Reset state while the pins toggle.
        repeat (4) begin
            TRACEDATA = 4'($urandom_range(0, 15));
            @(posedge trace_clk);
        end
        #1;
        chk("rst.valid", trace_valid, 0);
        chk("rst.data", trace_data, 8'h00);
        chk("rst.synced", synced, 0);
        chk("rst.realign", realign, 0);
        chk("rst.overflow", overflow, 0);
        chk("rst.drop", drop_count, 0);
        reset = 1'b1;
        nib(4'h3); nib(4'hC); nib(4'h9);
        chk("post_rst.synced", synced, 0);

        // Acquisition with the consumer always ready.
        trace_ready = 1'b1;
        repeat (7) nib(4'hF);
        nib(4'h7);
        chk("acq.synced_early", synced, 0);
        nib(4'h4);
        chk("acq.synced", synced, 1);
        chk("acq.v0", trace_valid, 0);
        nib(4'h3);
        chk("acq.v1", trace_valid, 0);
        nib(4'h2);
        chk("acq.b0.valid", trace_valid, 1);
        chk("acq.b0", trace_data, 8'h34);
        nib(4'h1);
        chk("acq.popped", trace_valid, 0);
        nib(4'h0);
        chk("acq.b1.valid", trace_valid, 1);
        chk("acq.b1", trace_data, 8'h12);
        enable = 1'b0;
        @(posedge trace_clk); #1;
        chk("acq.drained", trace_valid, 0);
        chk("acq.unsync", synced, 0);
        trace_ready = 1'b0;

        // Misaligned resync: one extra nibble shifts the byte boundary.
        enable = 1'b1;
        sync_seq();
        send_byte(8'h21);
        nib(4'h0);
        repeat (7) nib(4'hF);
        nib(4'h7);
        chk("mis.realign_pre", realign, 0);
        nib(4'hA);
        chk("mis.realign", realign, 1);
        chk("mis.synced", synced, 1);
        nib(4'h5);
        chk("mis.realign_post", realign, 0);
        nib(4'h0);
        enable = 1'b0;
        pop_chk("mis.q0", 8'h21);
        pop_chk("mis.q1", 8'hF0);
        pop_chk("mis.q2", 8'hFF);
        pop_chk("mis.q3", 8'hFF);
        pop_chk("mis.q4", 8'hFF);
        pop_chk("mis.q5", 8'h5A);
        chk("mis.empty", trace_valid, 0);

        // Aligned sync is forwarded and does not pulse realign.
        enable = 1'b1;
        sync_seq();
        send_byte(8'h21);
        repeat (7) nib(4'hF);
        nib(4'h7);
        nib(4'hA);
        chk("al.realign", realign, 0);
        nib(4'h5);
        chk("al.realign2", realign, 0);
        nib(4'h0);
        enable = 1'b0;
        pop_chk("al.q0", 8'h21);
        pop_chk("al.q1", 8'hFF);
        pop_chk("al.q2", 8'hFF);
        pop_chk("al.q3", 8'hFF);
        pop_chk("al.q4", 8'h7F);
        pop_chk("al.q5", 8'h5A);
        chk("al.empty", trace_valid, 0);

        // Overflow: 18 bytes into 16 slots, then clear.
        enable = 1'b1;
        sync_seq();
        for (int i = 0; i < 18; i++) send_byte(8'h80 + 8'(i));
        nib(4'h0);
        enable = 1'b0;
        chk("ovf.flag", overflow, 1);
        chk("ovf.drop", drop_count, 2);
        for (int i = 0; i < 15; i++) pop_chk("ovf.q", 8'h80 + 8'(i));
        chk("ovf.last.valid", trace_valid, 1);
        chk("ovf.last", trace_data, 8'h8F);
        chk("ovf.sticky", overflow, 1);
        clear = 1'b1;
        @(posedge trace_clk); #1;
        clear = 1'b0;
        chk("clr.valid", trace_valid, 0);
        chk("clr.overflow", overflow, 0);
        chk("clr.drop", drop_count, 0);

        // Push while full with a same-cycle pop: nothing is dropped.
        enable = 1'b1;
        sync_seq();
        for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i));
        nib(4'h0);
        chk("frw.head0", trace_data, 8'h40);
        nib(4'h5);
        TRACEDATA = 4'h0;
        trace_ready = 1'b1;
        @(posedge trace_clk); #1;
        trace_ready = 1'b0;
        enable = 1'b0;
        chk("frw.overflow", overflow, 0);
        chk("frw.drop", drop_count, 0);
        for (int i = 1; i < 16; i++) pop_chk("frw.q", 8'h40 + 8'(i));
        pop_chk("frw.new", 8'h50);
        chk("frw.empty", trace_valid, 0);

        // Enable dropped mid-byte: sync lost, queued data stays readable.
        enable = 1'b1;
        sync_seq();
        send_byte(8'h11);
        nib(4'h3);
        chk("en.synced", synced, 1);
        enable = 1'b0;
        nib(4'h4);
        chk("en.unsync", synced, 0);
        enable = 1'b1;
        nib(4'h4); nib(4'h5); nib(4'h6);
        pop_chk("en.kept", 8'h11);
        nib(4'h1); nib(4'h2);
        chk("en.no_resume", trace_valid, 0);
        sync_seq();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        nib(4'h0);
        chk("en.resume", trace_data, 8'h01);

        // Asynchronous reset with five bytes queued.
        #2;
        reset = 1'b0;
        #1;
        chk("arst.valid", trace_valid, 0);
        chk("arst.synced", synced, 0);
        #10;
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trace_port_receiver.md
# trace_port_receiver

Capture-side counterpart of the 4-bit parallel trace port: samples TRACEDATA on trace_clk, hunts for the full-frame synchronization pattern to establish byte alignment, and assembles nibble pairs (low nibble first) into bytes. Bytes go into a first-word-fall-through FIFO, which downstream logic drains with a valid/ready handshake. The block sits between the trace connector pins and the trace packet decoder/capture buffer.

## Interface
- pFIFO_AW, 4: FIFO address width; depth = 2**pFIFO_AW bytes.
- trace_clk  input  1  trace port clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- TRACEDATA  input  4  trace port nibble, sampled every rising edge.
- enable  input  1  1 = receive; 0 = forces HUNT and ignores TRACEDATA.
- clear  input  1  synchronous; empties the FIFO and clears overflow and drop_count.
- trace_data  output  8  FIFO head byte.
- trace_valid  output  1  FIFO not empty.
- trace_ready  input  1  consumer accepts trace_data when trace_valid & trace_ready.
- synced  output  1  1 while in SYNCED state.
- realign  output  1  one-cycle pulse on a misaligned sync that corrects alignment.
- overflow  output  1  sticky; set when a byte is dropped because the FIFO is full.
- drop_count  output  8  number of dropped bytes, saturates at 255.

## Operation
- Input register td_q <= TRACEDATA. An 8-nibble shift register holds the last 8 td_q values, newest on top.
- Sync match: the last 8 nibbles, oldest to newest, are F,F,F,F,F,F,F,7. This is the byte stream FF FF FF 7F sent low nibble first.
- States:
  - HUNT: no bytes are written. On a match, go to SYNCED with phase = 0; the next nibble is a low nibble.
  - SYNCED, phase 0: store td_q as lo; phase <= 1.
  - SYNCED, phase 1: write {td_q, lo} to the FIFO; phase <= 0.
- Aligned sync (match while in phase 1): the 7F byte is written normally; no other action.
- Misaligned sync (match while in phase 0): the nibble is not stored; phase stays 0; realign pulses for one cycle. The next nibble is a low nibble.
- Sync bytes received in SYNCED are forwarded. Stripping them is the decoder's job.
- enable = 0: state <= HUNT, shift register <= 0, phase <= 0. FIFO contents are kept and remain readable.
- FIFO write when full:
  - If a read also happens in the same cycle, the write is accepted and the occupancy is unchanged.
  - Otherwise the byte is dropped, overflow <= 1, and drop_count increments, saturating at 255.
- clear has priority over a simultaneous write or read: FIFO empty, overflow = 0, drop_count = 0. clear does not change state, phase, or the shift register.
- Pointers are pFIFO_AW+1 bits and wrap naturally. Full and empty are derived from the pointer MSBs.

## Timing
- Reset values:
  - trace_valid = 0, synced = 0, realign = 0, overflow = 0, drop_count = 0.
  - trace_data = 8'h00, FIFO pointers = 0, state = HUNT.
  - td_q and the shift register = 0.
- Reset asserted mid-operation discards all FIFO contents and returns to HUNT immediately, without waiting for a clock edge.
- Nibble presented before edge N is in td_q after edge N.
- Sync detection: if the final 7 nibble is presented before edge N, synced = 1 after edge N+1. The nibble presented before edge N+1 is the first low nibble.
- Byte latency: high nibble presented before edge N → byte written at edge N+1 → trace_valid = 1 and trace_data valid after edge N+1.
- Read: the handshake at edge M pops the head; the next byte is on trace_data after edge M, with no bubble.
- realign is high for exactly the cycle after the edge that registered the misaligned match.
- Sustained input is 1 byte per 2 clocks. The consumer needs ready ≥ 50% of the time to avoid overflow.

## Test plan
- Reset: hold reset = 0, drive random TRACEDATA → all outputs at their reset values; releasing reset leaves synced = 0 until a sync is seen.
- Acquisition: nibbles F×7, 7, then 4,3,2,1 with trace_ready = 1 → synced = 1; bytes 0x34 then 0x12 appear, each 2 clocks after its high nibble.
- Misaligned resync: once synced, insert one extra nibble 0, then sync, then A,5 → realign pulses once; next byte is 0x5A. An aligned sync gives no pulse and forwards FF FF FF 7F.
- Overflow: trace_ready = 0, stream 18 bytes into a depth-16 FIFO → 16 bytes held in order; overflow = 1; drop_count = 2. clear → trace_valid = 0, overflow = 0, drop_count = 0.
- Full with simultaneous read/write: at full, pulse trace_ready for one cycle on a write cycle → no drop; occupancy stays 16; the oldest byte is popped.
- Enable/reset mid-stream: enable = 0 mid-byte → synced = 0 next cycle; FIFO still drains; bytes resume only after a new sync. Asserting reset with 5 bytes queued → trace_valid = 0 immediately.
